// File: rtl/lfsr_draw_arbiter.sv
// Round-robin arbiter that hands out draws from one shared external 16-bit LFSR.
// The optional LFSR_LOCKUP_GUARD_EN macro enables a sticky all-zero lockup guard.
module lfsr_draw_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 16,
    parameter int RAND_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [RAND_W-1:0] lfsr_i,
    output logic              lfsr_en_o,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [RAND_W-1:0] rand_o,
    output logic              rand_vld_o,
    output logic              busy_o,
    output logic [15:0]       step_cnt_o,
    output logic              period_o,
    output logic              lockup_o
);

    localparam int          PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] STEP_LAST = 16'd65534;

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_SERVE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [RAND_W-1:0]   rand_q, rand_d;
    logic                vld_q, vld_d;
    logic [15:0]         step_q, step_d;
    logic                period_q, period_d;
    logic                lock_q, lock_d;

    logic                active;
    logic                zero_hit;
    logic                win_vld;
    logic [PW-1:0]       win_idx;
    logic                grant;
    logic                go;

    assign active = (state_q != S_IDLE);
    assign go     = start_i && !stop_i;

`ifdef LFSR_LOCKUP_GUARD_EN
    // An all-zero source would never leave zero; refuse to step or grant from it.
    assign zero_hit = active && (lfsr_i == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            rand_q   <= '0;
            vld_q    <= 1'b0;
            step_q   <= '0;
            period_q <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rand_q   <= rand_d;
            vld_q    <= vld_d;
            step_q   <= step_d;
            period_q <= period_d;
            lock_q   <= lock_d;
        end
    end

    // Scan from the pointer upward with wrap; lowest offset wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (req_i[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_WARM;
            S_WARM: begin
                if (stop_i)                          state_d = S_IDLE;
                else if (!zero_hit && wcnt_q == 8'd1) state_d = S_SERVE;
            end
            S_SERVE: if (stop_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_en_o = !stop_i && !zero_hit &&
                    ((state_q == S_WARM) || (state_q == S_SERVE && win_vld));
        grant     = (state_q == S_SERVE) && lfsr_en_o;

        wcnt_d = wcnt_q;
        if (state_q == S_IDLE && go)        wcnt_d = 8'(WARMUP);
        else if (state_q == S_WARM && lfsr_en_o) wcnt_d = wcnt_q - 8'd1;

        step_d   = step_q;
        period_d = 1'b0;
        if (state_q == S_IDLE && go) begin
            step_d = '0;
        end else if (lfsr_en_o) begin
            if (step_q == STEP_LAST) begin
                step_d   = '0;
                period_d = 1'b1;
            end else begin
                step_d = step_q + 16'd1;
            end
        end

        gnt_d = '0;
        for (int i = 0; i < N_REQ; i++) gnt_d[i] = grant && (win_idx == PW'(i));
        vld_d  = grant;
        rand_d = grant ? lfsr_i : rand_q;
        ptr_d  = ptr_q;
        if (grant) ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);

        lock_d = lock_q || zero_hit;
    end

    assign gnt_o      = gnt_q;
    assign rand_o     = rand_q;
    assign rand_vld_o = vld_q;
    assign busy_o     = active;
    assign step_cnt_o = step_q;
    assign period_o   = period_q;
    assign lockup_o   = lock_q;

endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// Bench for lfsr_draw_arbiter: models the external LFSR and predicts grants, draws and step counts.
module tb_lfsr_draw_arbiter;

    localparam int N  = 4;
    localparam int WU = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [N-1:0] req = '0;
    logic [15:0]  lfsr_i;
    logic         en, vld, busy, period, lock;
    logic [N-1:0] gnt;
    logic [15:0]  rnd, step;

    logic [15:0]  lfsr_q, lfsr_seed = 16'h0001;
    logic         lfsr_load = 1'b0, force_zero = 1'b0;

    int           n_chk = 0, n_fail = 0;
    int           m_ptr = 0, m_step = 0;
    logic [15:0]  m_rand = '0;

    lfsr_draw_arbiter #(.N_REQ(N), .WARMUP(WU), .RAND_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .req_i(req),
        .lfsr_i(lfsr_i), .lfsr_en_o(en), .gnt_o(gnt), .rand_o(rnd),
        .rand_vld_o(vld), .busy_o(busy), .step_cnt_o(step), .period_o(period),
        .lockup_o(lock)
    );

    always #5 clk = ~clk;

    // Maximal-length 16-bit Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk)
        if (lfsr_load)  lfsr_q <= lfsr_seed;
        else if (en)    lfsr_q <= lfsr_next(lfsr_q);

    assign lfsr_i = force_zero ? 16'h0000 : lfsr_q;

    task automatic load_seed(input logic [15:0] v);
        @(negedge clk); lfsr_seed = v; lfsr_load = 1'b1;
        @(negedge clk); lfsr_load = 1'b0;
    endtask

    task automatic do_warm();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (WU) @(negedge clk);
        m_step = WU;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_seed(16'h0001);
        @(negedge clk);
        n_chk++;
        if ({gnt, rnd, vld, busy, step, period, lock, en} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: gnt=%b rand=%h vld=%b busy=%b step=%0d per=%b lock=%b en=%b want all 0",
                     gnt, rnd, vld, busy, step, period, lock, en);
        end
        rst = 1'b0; m_ptr = 0; m_rand = '0; m_step = 0;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || en !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", busy, en);
        end
    endtask

    task automatic test_warmup();
        int n;
        @(negedge clk); start = 1'b1; #1;
        n_chk++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL idle_en: got %b want 0", en); end
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 300) begin
            #1;
            if (en !== 1'b1) break;
            n_chk++;
            if (busy !== 1'b1 || gnt !== '0) begin
                n_fail++; $display("FAIL warm_cycle: busy=%b gnt=%b want 1 0000", busy, gnt);
            end
            n++;
            @(negedge clk);
        end
        m_step = WU;
        n_chk++;
        if (n != WU) begin n_fail++; $display("FAIL warm_len: got %0d want %0d", n, WU); end
        n_chk++;
        if (lfsr_i !== lfsr_adv(16'h0001, WU)) begin
            n_fail++; $display("FAIL warm_lfsr: got %h want %h", lfsr_i, lfsr_adv(16'h0001, WU));
        end
        n_chk++;
        if (step !== 16'(WU) || busy !== 1'b1) begin
            n_fail++; $display("FAIL warm_step: step=%0d busy=%b want %0d 1", step, busy, WU);
        end
    endtask

    task automatic test_single();
        logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req = 4'b0001;
            e = lfsr_adv(16'h0001, WU + i);
            @(posedge clk); #1;
            n_chk++;
            if (gnt !== 4'b0001 || rnd !== e || vld !== 1'b1) begin
                n_fail++; $display("FAIL single_draw%0d: gnt=%b rand=%h vld=%b want 0001 %h 1", i, gnt, rnd, vld, e);
            end
            m_rand = e; m_step++;
        end
        m_ptr = 1;
        @(negedge clk); req = '0;
        @(posedge clk); #1;
        n_chk++;
        if (gnt !== '0 || vld !== 1'b0 || rnd !== m_rand || step !== 16'(m_step)) begin
            n_fail++; $display("FAIL single_idle: gnt=%b vld=%b rand=%h step=%0d want 0000 0 %h %0d",
                               gnt, vld, rnd, step, m_rand, m_step);
        end
    endtask

    task automatic test_rr();
        int cnt [N];
        logic [15:0] seen [$];
        logic [N-1:0] eg;
        logic [15:0] e;
        int w, dup;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); req = 4'b1111;
            e = lfsr_q;
            w = rr_pick(req, m_ptr);
            eg = N'(1 << w);
            @(posedge clk); #1;
            n_chk++;
            if (gnt !== eg || rnd !== e || vld !== 1'b1) begin
                n_fail++; $display("FAIL rr_draw%0d: gnt=%b rand=%h vld=%b want %b %h 1", c, gnt, rnd, vld, eg, e);
            end
            for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
            seen.push_back(rnd);
            m_ptr = (w + 1) % N; m_rand = e; m_step++;
        end
        @(negedge clk); req = '0;
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (cnt[i] != 2) begin n_fail++; $display("FAIL rr_share%0d: got %0d want 2", i, cnt[i]); end
        end
        dup = 0;
        for (int i = 0; i < seen.size(); i++)
            for (int j = i + 1; j < seen.size(); j++)
                if (seen[i] === seen[j]) dup++;
        n_chk++;
        if (dup != 0) begin n_fail++; $display("FAIL rr_distinct: got %0d duplicates want 0", dup); end
    endtask

    task automatic test_random();
        logic [N-1:0] r, eg;
        logic [15:0] e;
        int w;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            req = r; #1;
            n_chk++;
            if (en !== (r != '0)) begin n_fail++; $display("FAIL rand_en%0d: got %b want %b", c, en, r != '0); end
            e = lfsr_q;
            w = rr_pick(r, m_ptr);
            eg = (w < 0) ? '0 : N'(1 << w);
            @(posedge clk); #1;
            if (w >= 0) begin m_ptr = (w + 1) % N; m_rand = e; m_step++; end
            n_chk++;
            if (gnt !== eg || vld !== (w >= 0) || rnd !== m_rand || step !== 16'(m_step)) begin
                n_fail++; $display("FAIL rand_cyc%0d: req=%b gnt=%b vld=%b rand=%h step=%0d want %b %b %h %0d",
                                   c, r, gnt, vld, rnd, step, eg, w >= 0, m_rand, m_step);
            end
        end
        @(negedge clk); req = '0;
    endtask

    task automatic test_stop();
        int w;
        @(negedge clk); req = 4'b0100; stop = 1'b1; #1;
        n_chk++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL stop_en: got %b want 0", en); end
        @(posedge clk); #1;
        n_chk++;
        if (gnt !== '0 || vld !== 1'b0 || busy !== 1'b0 || step !== 16'(m_step)) begin
            n_fail++; $display("FAIL stop_edge: gnt=%b vld=%b busy=%b step=%0d want 0000 0 0 %0d",
                               gnt, vld, busy, step, m_step);
        end
        @(negedge clk); req = '0; start = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop: busy=%b want 0", busy); end
        @(negedge clk); start = 1'b0; stop = 1'b0;
        // Restart; the round-robin pointer must survive the stop.
        do_warm();
        req = 4'b1111;
        w = rr_pick(req, m_ptr);
        @(posedge clk); #1;
        m_ptr = (w + 1) % N; m_step++;
        n_chk++;
        if (gnt !== N'(1 << w) || step !== 16'(m_step)) begin
            n_fail++; $display("FAIL ptr_held: gnt=%b step=%0d want %b %0d", gnt, step, N'(1 << w), m_step);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); req = 4'b1111;
        @(posedge clk); #2; rst = 1'b1; #1;
        n_chk++;
        if ({gnt, vld, busy, step, rnd} !== '0) begin
            n_fail++; $display("FAIL async_rst: gnt=%b vld=%b busy=%b step=%0d rand=%h want all 0",
                               gnt, vld, busy, step, rnd);
        end
        @(negedge clk); req = '0;
        @(negedge clk); rst = 1'b0;
        m_ptr = 0; m_rand = '0; m_step = 0;
        do_warm();
        req = 4'b1111;
        @(posedge clk); #1;
        m_ptr = 1;
        n_chk++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ptr_reset: gnt=%b want 0001", gnt); end
        @(negedge clk); req = '0;
    endtask

    task automatic test_lockup();
        @(negedge clk); force_zero = 1'b1; req = 4'b0001; #1;
`ifdef LFSR_LOCKUP_GUARD_EN
        n_chk++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL lock_en: got %b want 0", en); end
        @(posedge clk); #1;
        n_chk++;
        if (gnt !== '0 || vld !== 1'b0 || lock !== 1'b1) begin
            n_fail++; $display("FAIL lock_set: gnt=%b vld=%b lock=%b want 0000 0 1", gnt, vld, lock);
        end
        @(negedge clk); force_zero = 1'b0; req = '0;
        @(posedge clk); #1;
        n_chk++;
        if (lock !== 1'b1) begin n_fail++; $display("FAIL lock_sticky: got %b want 1", lock); end
`else
        n_chk++;
        if (en !== 1'b1) begin n_fail++; $display("FAIL nolock_en: got %b want 1", en); end
        @(posedge clk); #1;
        n_chk++;
        if (gnt !== 4'b0001 || rnd !== 16'h0000 || lock !== 1'b0) begin
            n_fail++; $display("FAIL nolock: gnt=%b rand=%h lock=%b want 0001 0000 0", gnt, rnd, lock);
        end
        @(negedge clk); force_zero = 1'b0; req = '0;
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_ptr = 0; m_rand = '0; m_step = 0;
        n_chk++;
        if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_clear: got %b want 0", lock); end
    endtask

    task automatic test_period();
        logic [15:0] seed;
        int pulses, after, cyc;
        seed = 16'($urandom_range(1, 65535));
        load_seed(seed);
        do_warm();
        req = 4'b0001;
        pulses = 0; after = 0; cyc = 0;
        while (cyc < 70000 && after < 5) begin
            @(posedge clk); #1;
            cyc++;
            if (pulses > 0) after++;
            if (period === 1'b1) begin
                pulses++;
                n_chk++;
                if (step !== 16'h0000 || lfsr_i !== seed) begin
                    n_fail++; $display("FAIL period_wrap: step=%0d lfsr=%h want 0 %h", step, lfsr_i, seed);
                end
            end
        end
        @(negedge clk); req = '0;
        n_chk++;
        if (pulses != 1) begin n_fail++; $display("FAIL period_pulses: got %0d want 1", pulses); end
        n_chk++;
        if (cyc != 65535 - WU + 5) begin
            n_fail++; $display("FAIL period_len: got %0d cycles want %0d", cyc, 65535 - WU + 5);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_single();
        test_rr();
        test_random();
        test_stop();
        test_async_reset();
        test_lockup();
        test_period();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within 5ms");
        $fatal(1);
    end

endmodule
